set_sequencer: RTL and testbench
================================

SET_SEQUENCER -- requirements
Module: set_sequencer

Interface
REQ-001 Parameter NUM_SETS, 150, sets processed per run.
REQ-002 Parameter SET_WORDS, 1665, words per set in memory (1 header + template + window).
REQ-003 Parameter TEMP_WORDS, 64, template words per set.
REQ-004 Parameter WIN_WORDS, 1600, window words per set.
REQ-005 Parameter HDR_MAGIC, 32'h42, required header word value.
REQ-006 Parameter RES_BASE, 21'h1F_0000, result write region base.
REQ-007 One clock; reset is asynchronous and active-low: clk input 1 system clock; rst_n input 1 async active-low reset.
REQ-008 in_flag input 32: bit16 start pulse, bit17 abort pulse, other bits ignored.
REQ-009 rd_req output 1; req_addr output 21; rd_data input 32, valid exactly one cycle after rd_req.
REQ-010 stream_data output 32; tem_valid/tem_ready and win_valid/win_ready: output/input 1 each, valid/ready handshakes to template and window loaders.
REQ-011 result_ready input 1; greatestNCCLog2 input 64; greatestWindowIndex input 9.
REQ-012 FPGA_wr_en output 1; write_data output 32; flag_we output 1; out_flag output 32 (bit0 done, bit1 error, bits[15:8] set index).

Function
REQ-013 States: IDLE, HDR, TEMP, WIN, WAIT_RES, WRITE, NEXT, DONE, ERR.
REQ-014 IDLE -> HDR on in_flag[16]=1; start ignored in all other states.
REQ-015 Set base = set*SET_WORDS, computed by running accumulation (no multiplier), width 21.
REQ-016 HDR issues one read at base; rd_data==HDR_MAGIC -> TEMP, else -> ERR.
REQ-017 TEMP reads base+1..base+TEMP_WORDS; WIN reads base+TEMP_WORDS+1..base+SET_WORDS-1; addresses strictly ascending, no gaps or repeats.
REQ-018 Returned data enters a 2-entry FIFO; rd_req asserted only when FIFO count + in-flight - pop-this-cycle < 2; no word ever dropped.
REQ-019 FIFO head drives stream_data; tem_valid in TEMP, win_valid in WIN; pop on valid&&ready; sustained ready gives one word/cycle.
REQ-020 TEMP -> WIN after the TEMP_WORDS-th handshake; WIN -> WAIT_RES after the WIN_WORDS-th; template words never appear on win_valid.
REQ-021 WAIT_RES holds until result_ready=1, then latches both result inputs and enters WRITE.
REQ-022 WRITE asserts FPGA_wr_en 3 consecutive cycles, req_addr = RES_BASE+set*4+{0,1,2}, write_data = NCC[63:32], NCC[31:0], {23'b0,index}.
REQ-023 NEXT increments set; set==NUM_SETS-1 -> DONE, else -> HDR.
REQ-024 DONE: one-cycle flag_we, out_flag={16'b0,set,8'h01}, then IDLE.
REQ-025 ERR: one-cycle flag_we, out_flag={16'b0,set,8'h02}, then IDLE.
REQ-026 Abort (in_flag[17]) in any state -> IDLE next cycle, FIFO flushed, in-flight return discarded, no flag_we; abort wins over same-cycle start.
REQ-027 rd_req and FPGA_wr_en never asserted in the same cycle.

Reset
REQ-028 rst_n low: state IDLE, set=0, FIFO empty, all outputs 0, independent of clk.
REQ-029 Reset mid-set discards all progress; next start begins at set 0.

Structure
REQ-030 State enum, out_flag bit positions, and default size parameters in shared package astro_pkg.
REQ-031 One sub-module: seq_fifo2 (2-entry FIFO with count output).

Verification
REQ-032 Memory model matching REQ-009, NUM_SETS=2, headers 0x42, all readies high -> 2*1665 reads, 64 tem and 1600 win beats per set, addresses 0..3329, out_flag=32'h0000_0101.
REQ-033 Random tem_ready/win_ready throttling -> downstream sequence identical to memory contents, FIFO never overflows.
REQ-034 Set 1 header 0x41 -> ERR, out_flag=32'h0000_0102, no set-1 template beats.
REQ-035 result_ready with NCC=64'hDEAD_BEEF_0123_4567, index=9'd300, set 0 -> writes at 21'h1F_0000..2: DEADBEEF, 01234567, 0000012C.
REQ-036 Abort mid-WIN with read in flight -> IDLE next cycle, no valids, fresh start re-reads from address 0.
REQ-037 rst_n pulsed low mid-TEMP between clock edges -> outputs 0 immediately, restart processes set 0.

Source files
------------

// File: rtl/astro_pkg.sv
// ============================================================================
// astro_pkg : shared states, flag bit positions and default sizes
// Rev 1.0
// ============================================================================
`default_nettype none

package astro_pkg;

    localparam int unsigned DEF_NUM_SETS   = 150;
    localparam int unsigned DEF_SET_WORDS  = 1665;
    localparam int unsigned DEF_TEMP_WORDS = 64;
    localparam int unsigned DEF_WIN_WORDS  = 1600;
    localparam logic [31:0] DEF_HDR_MAGIC  = 32'h42;
    localparam logic [20:0] DEF_RES_BASE   = 21'h1F_0000;

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned SET_W  = 8;

    localparam int unsigned IN_START_BIT = 16;
    localparam int unsigned IN_ABORT_BIT = 17;

    localparam int unsigned OUT_DONE_BIT = 0;
    localparam int unsigned OUT_ERR_BIT  = 1;
    localparam int unsigned OUT_SET_LSB  = 8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_HDR      = 4'd1,
        ST_TEMP     = 4'd2,
        ST_WIN      = 4'd3,
        ST_WAIT_RES = 4'd4,
        ST_WRITE    = 4'd5,
        ST_NEXT     = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERR      = 4'd8
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/seq_fifo2.sv
// ============================================================================
// seq_fifo2 : two-entry FIFO with occupancy count and synchronous flush
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_fifo2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/set_sequencer.sv
// ============================================================================
// set_sequencer : reads header/template/window sets from memory, streams them
// to the loaders, and writes each set's correlation result back. Rev 1.0
// ============================================================================
`default_nettype none

module set_sequencer
    import astro_pkg::*;
#(
    parameter int unsigned       NUM_SETS   = DEF_NUM_SETS,
    parameter int unsigned       SET_WORDS  = DEF_SET_WORDS,
    parameter int unsigned       TEMP_WORDS = DEF_TEMP_WORDS,
    parameter int unsigned       WIN_WORDS  = DEF_WIN_WORDS,
    parameter logic [31:0]       HDR_MAGIC  = DEF_HDR_MAGIC,
    parameter logic [ADDR_W-1:0] RES_BASE   = DEF_RES_BASE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       in_flag,
    output logic              rd_req,
    output logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       rd_data,
    output logic [31:0]       stream_data,
    output logic              tem_valid,
    input  logic              tem_ready,
    output logic              win_valid,
    input  logic              win_ready,
    input  logic              result_ready,
    input  logic [63:0]       greatestNCCLog2,
    input  logic [8:0]        greatestWindowIndex,
    output logic              FPGA_wr_en,
    output logic [31:0]       write_data,
    output logic              flag_we,
    output logic [31:0]       out_flag
);

    localparam int unsigned CNT_W = $clog2(SET_WORDS + 1);

    seq_state_e        state_q, state_d;
    logic [SET_W-1:0]  set_q, set_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  rd_left_q, rd_left_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              hdr_issued_q, hdr_issued_d;
    logic              inflight_q;
    logic [1:0]        wr_idx_q, wr_idx_d;
    logic [63:0]       ncc_q, ncc_d;
    logic [8:0]        widx_q, widx_d;

    logic              start;
    logic              abort;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic              fifo_room;
    logic              unused_flag_bits;

    assign start            = in_flag[IN_START_BIT];
    assign abort            = in_flag[IN_ABORT_BIT];
    assign unused_flag_bits = ^{in_flag[31:18], in_flag[15:0]};

    // Occupancy after this cycle's pop, counting the word already on its way back.
    assign fifo_room = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, fifo_pop});

    seq_fifo2 #(
        .WIDTH(32)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (abort),
        .push_i     (fifo_push),
        .push_data_i(rd_data),
        .pop_i      (fifo_pop),
        .head_o     (stream_data),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        set_d        = set_q;
        base_d       = base_q;
        rd_addr_d    = rd_addr_q;
        rd_left_d    = rd_left_q;
        beat_d       = beat_q;
        hdr_issued_d = hdr_issued_q;
        wr_idx_d     = wr_idx_q;
        ncc_d        = ncc_q;
        widx_d       = widx_q;
        rd_req       = 1'b0;
        req_addr     = rd_addr_q;
        tem_valid    = 1'b0;
        win_valid    = 1'b0;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        FPGA_wr_en   = 1'b0;
        write_data   = '0;
        flag_we      = 1'b0;
        out_flag     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_HDR;
                    set_d        = '0;
                    base_d       = '0;
                    rd_addr_d    = '0;
                    hdr_issued_d = 1'b0;
                end
            end
            ST_HDR: begin
                if (!hdr_issued_q) begin
                    rd_req       = 1'b1;
                    rd_addr_d    = rd_addr_q + ADDR_W'(1);
                    hdr_issued_d = 1'b1;
                end
                if (inflight_q) begin
                    if (rd_data == HDR_MAGIC) begin
                        state_d   = ST_TEMP;
                        rd_left_d = CNT_W'(SET_WORDS - 1);
                        beat_d    = '0;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_TEMP, ST_WIN: begin
                // Window reads are prefetched while template words drain; FIFO order keeps them apart.
                fifo_push = inflight_q;
                tem_valid = (state_q == ST_TEMP) && !fifo_empty;
                win_valid = (state_q == ST_WIN) && !fifo_empty;
                fifo_pop  = (tem_valid && tem_ready) || (win_valid && win_ready);
                if ((rd_left_q != '0) && fifo_room) begin
                    rd_req    = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    rd_left_d = rd_left_q - CNT_W'(1);
                end
                if (fifo_pop) begin
                    if ((state_q == ST_TEMP) && (beat_q == CNT_W'(TEMP_WORDS - 1))) begin
                        state_d = ST_WIN;
                        beat_d  = '0;
                    end else if ((state_q == ST_WIN) && (beat_q == CNT_W'(WIN_WORDS - 1))) begin
                        state_d = ST_WAIT_RES;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            ST_WAIT_RES: begin
                if (result_ready) begin
                    ncc_d    = greatestNCCLog2;
                    widx_d   = greatestWindowIndex;
                    wr_idx_d = 2'd0;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                FPGA_wr_en = 1'b1;
                req_addr   = RES_BASE + ADDR_W'({set_q, 2'b00}) + ADDR_W'(wr_idx_q);
                case (wr_idx_q)
                    2'd0:    write_data = ncc_q[63:32];
                    2'd1:    write_data = ncc_q[31:0];
                    default: write_data = {23'b0, widx_q};
                endcase
                wr_idx_d = wr_idx_q + 2'd1;
                if (wr_idx_q == 2'd2) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (set_q == SET_W'(NUM_SETS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    set_d        = set_q + SET_W'(1);
                    base_d       = base_q + ADDR_W'(SET_WORDS);
                    rd_addr_d    = base_q + ADDR_W'(SET_WORDS);
                    hdr_issued_d = 1'b0;
                    state_d      = ST_HDR;
                end
            end
            ST_DONE: begin
                flag_we                = 1'b1;
                out_flag[OUT_SET_LSB +: SET_W] = set_q;
                out_flag[OUT_DONE_BIT] = 1'b1;
                state_d                = ST_IDLE;
            end
            ST_ERR: begin
                flag_we               = 1'b1;
                out_flag[OUT_SET_LSB +: SET_W] = set_q;
                out_flag[OUT_ERR_BIT] = 1'b1;
                state_d               = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            rd_req     = 1'b0;
            rd_addr_d  = rd_addr_q;
            tem_valid  = 1'b0;
            win_valid  = 1'b0;
            fifo_push  = 1'b0;
            fifo_pop   = 1'b0;
            FPGA_wr_en = 1'b0;
            write_data = '0;
            flag_we    = 1'b0;
            out_flag   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            set_q        <= '0;
            base_q       <= '0;
            rd_addr_q    <= '0;
            rd_left_q    <= '0;
            beat_q       <= '0;
            hdr_issued_q <= 1'b0;
            inflight_q   <= 1'b0;
            wr_idx_q     <= 2'd0;
            ncc_q        <= '0;
            widx_q       <= '0;
        end else begin
            state_q      <= state_d;
            set_q        <= set_d;
            base_q       <= base_d;
            rd_addr_q    <= rd_addr_d;
            rd_left_q    <= rd_left_d;
            beat_q       <= beat_d;
            hdr_issued_q <= hdr_issued_d;
            inflight_q   <= rd_req;
            wr_idx_q     <= wr_idx_d;
            ncc_q        <= ncc_d;
            widx_q       <= widx_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_set_sequencer.sv
// ============================================================================
// tb_set_sequencer : directed bench for set_sequencer with a one-cycle memory
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_set_sequencer;

    localparam int SETW = 1665;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_flag;
    logic        rd_req;
    logic [20:0] req_addr;
    logic [31:0] rd_data = 32'h0;
    logic [31:0] stream_data;
    logic        tem_valid, win_valid;
    logic        tem_ready = 1'b1;
    logic        win_ready = 1'b1;
    logic        result_ready;
    logic [63:0] ncc;
    logic [8:0]  widx;
    logic        FPGA_wr_en;
    logic [31:0] write_data;
    logic        flag_we;
    logic [31:0] out_flag;

    logic throttle;
    logic hdr1_bad;
    logic mon_clr;

    int n_total = 0;
    int n_bad   = 0;

    int n_rd, addr_err, n_tem, n_win, str_err, conflict, n_wr, n_flag, sidx, mset;
    logic [20:0] exp_addr;
    logic [20:0] wr_addr [8];
    logic [31:0] wr_dat  [8];

    set_sequencer #(
        .NUM_SETS(2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_flag            (in_flag),
        .rd_req             (rd_req),
        .req_addr           (req_addr),
        .rd_data            (rd_data),
        .stream_data        (stream_data),
        .tem_valid          (tem_valid),
        .tem_ready          (tem_ready),
        .win_valid          (win_valid),
        .win_ready          (win_ready),
        .result_ready       (result_ready),
        .greatestNCCLog2    (ncc),
        .greatestWindowIndex(widx),
        .FPGA_wr_en         (FPGA_wr_en),
        .write_data         (write_data),
        .flag_we            (flag_we),
        .out_flag           (out_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [20:0] a);
        if ((int'(a) % SETW) == 0)
            return (int'(a) == SETW && hdr1_bad) ? 32'h41 : 32'h42;
        return {11'h5A3, a};
    endfunction

    always @(posedge clk) rd_data <= rd_req ? mem_word(req_addr) : 32'h0;

    always @(posedge clk) begin
        #1;
        tem_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        win_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Observes reads, stream beats, result writes and flags against the memory image.
    always @(negedge clk) begin
        if (mon_clr) begin
            n_rd = 0; addr_err = 0; n_tem = 0; n_win = 0; str_err = 0;
            conflict = 0; n_wr = 0; n_flag = 0; sidx = 0; mset = 0; exp_addr = '0;
        end else if (rst_n) begin
            if (rd_req) begin
                if (req_addr != exp_addr) addr_err++;
                if (FPGA_wr_en) conflict++;
                exp_addr = exp_addr + 21'd1;
                n_rd++;
            end
            if (tem_valid && tem_ready) begin
                if (sidx >= 64 || stream_data != mem_word(21'(mset * SETW + 1 + sidx))) str_err++;
                n_tem++;
                sidx++;
            end
            if (win_valid && win_ready) begin
                if (sidx < 64 || stream_data != mem_word(21'(mset * SETW + 1 + sidx))) str_err++;
                n_win++;
                sidx++;
            end
            if (sidx == SETW - 1) begin
                sidx = 0;
                mset++;
            end
            if (FPGA_wr_en) begin
                if (n_wr < 8) begin
                    wr_addr[n_wr] = req_addr;
                    wr_dat[n_wr]  = write_data;
                end
                n_wr++;
            end
            if (flag_we) n_flag++;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_flag(input logic [31:0] v);
        @(posedge clk);
        #1 in_flag = v;
        @(posedge clk);
        #1 in_flag = 32'h0;
    endtask

    task automatic wait_flag(input string tag, input logic [31:0] exp);
        int cyc = 0;
        while (flag_we !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_seen"}, flag_we, 1);
        check_val({tag, "_flag"}, out_flag, exp);
        @(negedge clk);
        #1 check_val({tag, "_one_cycle"}, flag_we, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_flag = 32'h0; throttle = 1'b0; hdr1_bad = 1'b0; mon_clr = 1'b0;
        result_ready = 1'b1; ncc = 64'hDEAD_BEEF_0123_4567; widx = 9'd300;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rd_req", rd_req, 0);
        check_val("rst_wr_en", FPGA_wr_en, 0);
        check_val("rst_flag_we", flag_we, 0);
        check_val("rst_out_flag", out_flag, 0);
        check_val("rst_req_addr", req_addr, 0);
        check_val("rst_valids", {tem_valid, win_valid}, 0);
        rst_n = 1'b1;

        // Full two-set run, readies high
        clr_mon();
        pulse_flag(32'h0001_0000);
        wait_flag("run1", 32'h0000_0101);
        @(negedge clk); #1;
        check_val("run1_reads", n_rd, 2 * SETW);
        check_val("run1_addr_err", addr_err, 0);
        check_val("run1_last_addr", exp_addr, 21'd3330);
        check_val("run1_tem", n_tem, 128);
        check_val("run1_win", n_win, 3200);
        check_val("run1_stream", str_err, 0);
        check_val("run1_conflict", conflict, 0);
        check_val("run1_nwr", n_wr, 6);
        check_val("run1_nflag", n_flag, 1);
        check_val("wr0_addr", wr_addr[0], 21'h1F_0000);
        check_val("wr0_data", wr_dat[0], 32'hDEAD_BEEF);
        check_val("wr1_addr", wr_addr[1], 21'h1F_0001);
        check_val("wr1_data", wr_dat[1], 32'h0123_4567);
        check_val("wr2_addr", wr_addr[2], 21'h1F_0002);
        check_val("wr2_data", wr_dat[2], 32'h0000_012C);
        check_val("wr3_addr", wr_addr[3], 21'h1F_0004);
        check_val("wr5_addr", wr_addr[5], 21'h1F_0006);

        // Random downstream throttling
        throttle = 1'b1;
        clr_mon();
        pulse_flag(32'h0001_0000);
        wait_flag("thr", 32'h0000_0101);
        @(negedge clk); #1;
        throttle = 1'b0;
        check_val("thr_stream", str_err, 0);
        check_val("thr_tem", n_tem, 128);
        check_val("thr_win", n_win, 3200);
        check_val("thr_reads", n_rd, 2 * SETW);

        // Bad header on set 1
        hdr1_bad = 1'b1;
        clr_mon();
        pulse_flag(32'h0001_0000);
        wait_flag("hdr", 32'h0000_0102);
        @(negedge clk); #1;
        hdr1_bad = 1'b0;
        check_val("hdr_tem", n_tem, 64);
        check_val("hdr_reads", n_rd, SETW + 1);
        check_val("hdr_nwr", n_wr, 3);

        // Abort and start together: abort wins
        clr_mon();
        pulse_flag(32'h0003_0000);
        repeat (4) @(negedge clk);
        #1 check_val("abort_over_start", n_rd, 0);

        // Abort mid-window with a read in flight
        clr_mon();
        pulse_flag(32'h0001_0000);
        begin
            int cyc = 0;
            while (n_win < 100 && cyc < 20000) begin @(negedge clk); #1; cyc++; end
            while (!rd_req && cyc < 20000) begin @(negedge clk); #1; cyc++; end
            check_val("abort_reached", (n_win >= 100) && rd_req, 1);
        end
        @(posedge clk);
        #1 in_flag = 32'h0002_0000;
        @(posedge clk);
        #1 in_flag = 32'h0;
        check_val("abort_valids", {tem_valid, win_valid, rd_req}, 0);
        repeat (5) @(negedge clk);
        #1 check_val("abort_no_flag", n_flag, 0);
        clr_mon();
        pulse_flag(32'h0001_0000);
        wait_flag("reabort", 32'h0000_0101);
        @(negedge clk); #1;
        check_val("reabort_addr_err", addr_err, 0);
        check_val("reabort_reads", n_rd, 2 * SETW);
        check_val("reabort_stream", str_err, 0);

        // Asynchronous reset between edges mid-template
        clr_mon();
        pulse_flag(32'h0001_0000);
        begin
            int cyc = 0;
            while (n_tem < 10 && cyc < 20000) begin @(negedge clk); #1; cyc++; end
            check_val("rst_reached", n_tem >= 10, 1);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("arst_rd_req", rd_req, 0);
        check_val("arst_tem_valid", tem_valid, 0);
        check_val("arst_req_addr", req_addr, 0);
        check_val("arst_stream", stream_data, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        clr_mon();
        pulse_flag(32'h0001_0000);
        wait_flag("rerst", 32'h0000_0101);
        @(negedge clk); #1;
        check_val("rerst_addr_err", addr_err, 0);
        check_val("rerst_reads", n_rd, 2 * SETW);
        check_val("rerst_stream", str_err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
